// File: rtl/float_to_int_seq.sv
// float_to_int_seq
// Multi-cycle float to signed integer converter. The float is split into
// {sign, exponent, mantissa}. The implicit-one mantissa goes into a working
// register, and that register is moved one bit per cycle toward the integer
// binary point. A single 1-bit shifter does this instead of a barrel shifter.
// Special inputs bypass the shifter through an override code:
// zero/subnormal, NaN, infinity, out of range, and the exact negative minimum.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset; discards any conversion
//   in_valid   float_in holds a value to convert
//   in_ready   converter is idle and can accept a value
//   float_in   float operand {sign, exp, mantissa}
//   out_valid  int_out / overflow / invalid are valid and held
//   out_ready  consumer accepts the result
//   int_out    two's-complement result
//   overflow   result was saturated
//   invalid    input was NaN
//
// Optional build macro FLOAT_TO_INT_ROUND_EN:
//   Defined: round to nearest, ties to even, using guard/sticky bits.
//   Undefined: truncate toward zero.
module float_to_int_seq #(
   parameter int int_size   = 16,
   parameter int float_size = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [float_size-1:0] float_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [int_size-1:0]   int_out,
   output logic                  overflow,
   output logic                  invalid
);

   // Float-format field widths: half, single and double precision.
   function automatic int exp_bits(input int fs);
      case (fs)
         16:      return 5;
         64:      return 11;
         default: return 8;
      endcase
   endfunction

   function automatic int man_bits(input int fs);
      case (fs)
         16:      return 10;
         64:      return 52;
         default: return 23;
      endcase
   endfunction

   localparam int E  = exp_bits(float_size);
   localparam int M  = man_bits(float_size);
   localparam int B  = (1 << (E - 1)) - 1;
   localparam int RW = M + int_size;
   // The longest shift is a right shift for the smallest normal exponent.
   localparam int CW = $clog2(M + B + 2) + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH, DONE} state_t;
   typedef enum logic [2:0] {OVR_NONE, OVR_ZERO, OVR_NAN, OVR_SAT, OVR_MIN} ovr_t;

   state_t              state_q, state_d;
   ovr_t                ovr_q, ovr_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [RW-1:0]       r_q, r_d;
   logic                left_q, left_d;
   logic                sign_q, sign_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic [int_size-1:0] int_out_q, int_out_d;
   logic                overflow_q, overflow_d;
   logic                invalid_q, invalid_d;
`ifdef FLOAT_TO_INT_ROUND_EN
   logic                guard_q, guard_d;
   logic                sticky_q, sticky_d;
   logic                round_up;
`endif

   logic                in_sign;
   logic [E-1:0]        in_exp;
   logic [M-1:0]        in_man;
   int                  e_val;
   ovr_t                dec_ovr;
   logic                dec_left;
   logic [CW-1:0]       dec_cnt;
   logic [int_size-1:0] mag_ext;
   logic [int_size-1:0] res;
   logic                sat;
   logic                nan;

   // Decode the incoming float into shift direction, shift count and override.
   always_comb begin
      {in_sign, in_exp, in_man} = float_in;
      e_val    = int'(in_exp) - B;
      dec_left = (e_val >= M);
      dec_cnt  = dec_left ? CW'(e_val - M) : CW'(M - e_val);
      dec_ovr  = OVR_NONE;
      if (&in_exp) begin
         dec_ovr = (in_man != '0) ? OVR_NAN : OVR_SAT;
      end else if (in_exp == '0) begin
         dec_ovr = OVR_ZERO;
      end else if (in_sign && (e_val == int_size - 1) && (in_man == '0)) begin
         dec_ovr = OVR_MIN;
      end else if (e_val >= int_size - 1) begin
         dec_ovr = OVR_SAT;
`ifndef FLOAT_TO_INT_ROUND_EN
      end else if (e_val < 0) begin
         dec_ovr = OVR_ZERO;
`endif
      end
      if (dec_ovr != OVR_NONE) begin
         dec_cnt = '0;
      end
   end

   // Next-state logic. The results are computed in FINISH, the only state
   // that writes them.
   always_comb begin
      state_d     = state_q;
      ovr_d       = ovr_q;
      cnt_d       = cnt_q;
      r_d         = r_q;
      left_d      = left_q;
      sign_d      = sign_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      int_out_d   = int_out_q;
      overflow_d  = overflow_q;
      invalid_d   = invalid_q;
      mag_ext     = {1'b0, r_q[int_size-2:0]};
      sat         = 1'b0;
      nan         = 1'b0;
`ifdef FLOAT_TO_INT_ROUND_EN
      guard_d     = guard_q;
      sticky_d    = sticky_q;
      round_up    = guard_q & (sticky_q | r_q[0]);
      mag_ext     = mag_ext + int_size'(round_up);
      // A carry into the sign position is only representable as the negative minimum.
      if (mag_ext[int_size-1] && !sign_q) begin
         sat = 1'b1;
      end
`endif
      res = sign_q ? -mag_ext : mag_ext;
      case (ovr_q)
         OVR_ZERO: res = '0;
         OVR_NAN: begin
            res = '0;
            nan = 1'b1;
         end
         OVR_SAT: sat = 1'b1;
         OVR_MIN: res = {1'b1, {(int_size-1){1'b0}}};
         default: ;
      endcase
      if (sat) begin
         res = sign_q ? {1'b1, {(int_size-1){1'b0}}} : {1'b0, {(int_size-1){1'b1}}};
      end

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d    = SHIFT;
               in_ready_d = 1'b0;
               r_d        = RW'({1'b1, in_man});
               left_d     = dec_left;
               cnt_d      = dec_cnt;
               sign_d     = in_sign;
               ovr_d      = dec_ovr;
`ifdef FLOAT_TO_INT_ROUND_EN
               guard_d    = 1'b0;
               sticky_d   = 1'b0;
`endif
            end
         end
         SHIFT: begin
            if (cnt_q == '0) begin
               state_d = FINISH;
            end else begin
               cnt_d = cnt_q - CW'(1);
               if (left_q) begin
                  r_d = r_q << 1;
               end else begin
                  r_d = r_q >> 1;
`ifdef FLOAT_TO_INT_ROUND_EN
                  guard_d  = r_q[0];
                  sticky_d = sticky_q | guard_q;
`endif
               end
            end
         end
         FINISH: begin
            int_out_d   = res;
            overflow_d  = sat;
            invalid_d   = nan;
            out_valid_d = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Single state register for the FSM, datapath and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ovr_q       <= OVR_NONE;
         cnt_q       <= '0;
         r_q         <= '0;
         left_q      <= 1'b0;
         sign_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         int_out_q   <= '0;
         overflow_q  <= 1'b0;
         invalid_q   <= 1'b0;
`ifdef FLOAT_TO_INT_ROUND_EN
         guard_q     <= 1'b0;
         sticky_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ovr_q       <= ovr_d;
         cnt_q       <= cnt_d;
         r_q         <= r_d;
         left_q      <= left_d;
         sign_q      <= sign_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         int_out_q   <= int_out_d;
         overflow_q  <= overflow_d;
         invalid_q   <= invalid_d;
`ifdef FLOAT_TO_INT_ROUND_EN
         guard_q     <= guard_d;
         sticky_q    <= sticky_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign int_out   = int_out_q;
   assign overflow  = overflow_q;
   assign invalid   = invalid_q;

endmodule

// File: tb/tb_float_to_int_seq.sv
// tb_float_to_int_seq
// Directed testbench for float_to_int_seq with int_size=16 and float_size=32.
// Expected integers and latencies are hand-derived from the float encodings.
module tb_float_to_int_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] float_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] int_out;
   logic        overflow;
   logic        invalid;

   int errors = 0;
   int checks = 0;

   float_to_int_seq #(.int_size(16), .float_size(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .float_in  (float_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .int_out   (int_out),
      .overflow  (overflow),
      .invalid   (invalid)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Hard stop in case some wait never returns.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      assert (got === expv) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, expv);
      end
   endtask

   // Wait until the converter is idle, then present one float for a single accept edge.
   task automatic applyStimulus(input logic [31:0] f);
      int n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkVal("in_ready_before_accept", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      float_in = f;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      float_in = $urandom();
   endtask

   // Count edges from the accept edge until out_valid appears, then compare the result.
   task automatic checkOutput(input string tag, input logic [15:0] expInt, input logic expOvf,
                              input logic expInv, input int expLat);
      int lat = -1;
      for (int i = 1; i <= 300; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      checkVal({tag, "_latency"}, 32'(lat), 32'(expLat));
      checkVal({tag, "_int_out"}, 32'(int_out), 32'(expInt));
      checkVal({tag, "_overflow"}, 32'(overflow), 32'(expOvf));
      checkVal({tag, "_invalid"}, 32'(invalid), 32'(expInv));
      if (out_ready) begin
         @(posedge clk);
         #1;
         checkVal({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
         checkVal({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      float_in  = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      checkVal("reset_in_ready", 32'(in_ready), 32'd1);
      checkVal("reset_out_valid", 32'(out_valid), 32'd0);
      checkVal("reset_int_out", 32'(int_out), 32'd0);
      checkVal("reset_overflow", 32'(overflow), 32'd0);
      checkVal("reset_invalid", 32'(invalid), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // 1.0: e=0, 23 right shifts.
      applyStimulus(32'h3F800000);
      checkOutput("one", 16'h0001, 1'b0, 1'b0, 25);

      // -100.0: e=6, 17 right shifts.
      applyStimulus(32'hC2C80000);
      checkOutput("neg100", 16'hFF9C, 1'b0, 1'b0, 19);

      // 3.5: e=1; truncates to 3, or rounds up to even 4.
      applyStimulus(32'h40600000);
`ifdef FLOAT_TO_INT_ROUND_EN
      checkOutput("three_half", 16'h0004, 1'b0, 1'b0, 24);
`else
      checkOutput("three_half", 16'h0003, 1'b0, 1'b0, 24);
`endif

      // 2.5: tie rounds to even 2; truncation also gives 2.
      applyStimulus(32'h40200000);
      checkOutput("two_half", 16'h0002, 1'b0, 1'b0, 24);

      // 40000.0: e=15, saturates positive.
      applyStimulus(32'h471C4000);
      checkOutput("pos_sat", 16'h7FFF, 1'b1, 1'b0, 2);

      // -32768.0: exact negative minimum, no overflow.
      applyStimulus(32'hC7000000);
      checkOutput("neg_min", 16'h8000, 1'b0, 1'b0, 2);

      // -inf saturates negative.
      applyStimulus(32'hFF800000);
      checkOutput("neg_inf", 16'h8000, 1'b1, 1'b0, 2);

      // NaN gives zero with invalid set.
      applyStimulus(32'h7FC00000);
      checkOutput("nan", 16'h0000, 1'b0, 1'b1, 2);

      // 0.25: e<0 gives zero; with rounding it takes 25 right shifts.
      applyStimulus(32'h3E800000);
`ifdef FLOAT_TO_INT_ROUND_EN
      checkOutput("quarter", 16'h0000, 1'b0, 1'b0, 27);
`else
      checkOutput("quarter", 16'h0000, 1'b0, 1'b0, 2);
`endif

      // Backpressure: the result must hold while out_ready is low.
      out_ready = 1'b0;
      applyStimulus(32'hC2C80000);
      checkOutput("bp_neg100", 16'hFF9C, 1'b0, 1'b0, 19);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         checkVal("bp_hold_int_out", 32'(int_out), 32'hFF9C);
         checkVal("bp_hold_out_valid", 32'(out_valid), 32'd1);
         checkVal("bp_hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkVal("bp_release_in_ready", 32'(in_ready), 32'd1);
      checkVal("bp_release_out_valid", 32'(out_valid), 32'd0);

      // Reset in the middle of a 1.0 conversion clears everything at once.
      applyStimulus(32'h3F800000);
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      checkVal("midreset_in_ready", 32'(in_ready), 32'd1);
      checkVal("midreset_out_valid", 32'(out_valid), 32'd0);
      checkVal("midreset_int_out", 32'(int_out), 32'd0);
      checkVal("midreset_overflow", 32'(overflow), 32'd0);
      checkVal("midreset_invalid", 32'(invalid), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // 2.0 after the reset converts normally.
      applyStimulus(32'h40000000);
      checkOutput("two_after_reset", 16'h0002, 1'b0, 1'b0, 24);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
